// File: rtl/mmio_bridge_pkg.sv
// Address map and decode helpers shared by the MMIO bridge files.
// Pure constants and a combinational decode function; no state.
package mmio_bridge_pkg;

  localparam int ADDR_W = 18;
  localparam int RAM_AW = 17;

  localparam logic [1:0]        IO_SEL_HI = 2'b11;
  localparam logic [ADDR_W-1:0] IO_BASE   = 18'h30000;
  localparam logic [ADDR_W-1:0] ADDR_UART = IO_BASE + 18'h0;
  localparam logic [ADDR_W-1:0] ADDR_CLK  = IO_BASE + 18'h4;

  typedef enum logic [1:0] {
    IO_NONE,
    IO_UART,
    IO_CLK,
    IO_OTHER
  } io_sel_e;

  // ADDR_CLK covers a 4-byte window; the low two bits pick the byte lane.
  function automatic io_sel_e io_decode(input logic [ADDR_W-1:0] a);
    io_sel_e sel;
    if (a[ADDR_W-1:ADDR_W-2] != IO_SEL_HI) sel = IO_NONE;
    else if (a == ADDR_UART)               sel = IO_UART;
    else if (a[ADDR_W-1:2] == ADDR_CLK[ADDR_W-1:2]) sel = IO_CLK;
    else                                   sel = IO_OTHER;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// CPU-side memory bus between the CPU core and the MMIO bridge.
// master = CPU, slave = bridge; read data returns one cycle after the address.
interface mmio_bridge_if;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;

  modport master (output rdy_in, cpu_a, cpu_dout, cpu_wr,
                  input  cpu_din, io_buffer_full);
  modport slave  (input  rdy_in, cpu_a, cpu_dout, cpu_wr,
                  output cpu_din, io_buffer_full);
endinterface

// File: rtl/mmio_tx_fifo.sv
// Show-ahead byte FIFO: pop_dat is the head whenever empty is low.
// Latency: push visible at head the cycle after; push at full is refused unless popping.
module mmio_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               push_dat,
  input  logic                     pop,
  output logic [7:0]               pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign pop_dat = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/mmio_bridge.sv
// CPU bus decode to RAM / UART TX FIFO / RX / cycle counter / stop latch; MMIO_CYCLE_SNAPSHOT_EN adds a coherent counter snapshot.
// Latency: read data 1 cycle after address; io_buffer_full back-pressures the CPU near TX full.
module mmio_bridge #(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mmio_bridge_if.slave        cpu,
  output logic [16:0]         ram_a,
  output logic                ram_wr,
  output logic [7:0]          ram_dout,
  input  logic [7:0]          ram_din,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_pop,
  output logic                sim_stop,
  output logic                tx_overflow
);
  import mmio_bridge_pkg::*;

  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic [ADDR_W-1:0] addr;
  logic [13:0]       unused_addr_hi;
  io_sel_e           io_sel;
  logic [1:0]        clk_k;
  logic [7:0]        clk_byte;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              rx_pop_c;

  logic [31:0]       cnt_q, cnt_d;
  logic              sel_io_q, sel_io_d;
  logic [7:0]        io_rdata_q, io_rdata_d;
  logic              stop_pend_q, stop_pend_d;
  logic              sim_stop_q, sim_stop_d;
  logic              tx_overflow_q, tx_overflow_d;
`ifdef MMIO_CYCLE_SNAPSHOT_EN
  logic [31:0]       snap_q, snap_d;
`endif

  assign addr           = cpu.cpu_a[ADDR_W-1:0];
  assign unused_addr_hi = cpu.cpu_a[31:ADDR_W];
  assign io_sel         = io_decode(addr);
  assign clk_k          = addr[1:0];

  assign ram_a    = addr[RAM_AW-1:0];
  assign ram_dout = cpu.cpu_dout;
  assign ram_wr   = cpu.cpu_wr & (io_sel == IO_NONE) & cpu.rdy_in;

  assign cpu.cpu_din        = sel_io_q ? io_rdata_q : ram_din;
  assign cpu.io_buffer_full = (CW'(TX_DEPTH) - fifo_count) <= CW'(FULL_MARGIN);

  assign tx_valid    = ~fifo_empty;
  assign fifo_pop    = tx_valid & tx_ready;
  assign rx_pop      = rx_pop_c & ~rst_in;
  assign sim_stop    = sim_stop_q;
  assign tx_overflow = tx_overflow_q;

  // Byte 0 of the counter window captures the snapshot; upper bytes read it back.
`ifdef MMIO_CYCLE_SNAPSHOT_EN
  assign clk_byte = (clk_k == 2'd0) ? cnt_q[7:0] : snap_q[{clk_k, 3'b000} +: 8];
`else
  assign clk_byte = cnt_q[{clk_k, 3'b000} +: 8];
`endif

  always_comb begin
    cnt_d         = cnt_q + 32'd1;
    sel_io_d      = sel_io_q;
    io_rdata_d    = io_rdata_q;
    stop_pend_d   = stop_pend_q;
    sim_stop_d    = sim_stop_q | (stop_pend_q & fifo_empty);
    tx_overflow_d = tx_overflow_q;
    fifo_push     = 1'b0;
    rx_pop_c      = 1'b0;
`ifdef MMIO_CYCLE_SNAPSHOT_EN
    snap_d        = snap_q;
`endif
    if (cpu.rdy_in) begin
      sel_io_d   = (io_sel != IO_NONE);
      io_rdata_d = 8'h00;
      if (cpu.cpu_wr) begin
        // Zero bytes are padding from the firmware and never reach the UART.
        if (io_sel == IO_UART && cpu.cpu_dout != 8'h00 && !stop_pend_q) begin
          if (!fifo_full || fifo_pop) fifo_push = 1'b1;
          else                        tx_overflow_d = 1'b1;
        end
        if (io_sel == IO_CLK && clk_k == 2'd0) stop_pend_d = 1'b1;
      end else begin
        if (io_sel == IO_UART && rx_valid) begin
          io_rdata_d = rx_data;
          rx_pop_c   = 1'b1;
        end
        if (io_sel == IO_CLK) begin
          io_rdata_d = clk_byte;
`ifdef MMIO_CYCLE_SNAPSHOT_EN
          if (clk_k == 2'd0) snap_d = cnt_q;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q         <= '0;
      sel_io_q      <= 1'b0;
      io_rdata_q    <= '0;
      stop_pend_q   <= 1'b0;
      sim_stop_q    <= 1'b0;
      tx_overflow_q <= 1'b0;
`ifdef MMIO_CYCLE_SNAPSHOT_EN
      snap_q        <= '0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      sel_io_q      <= sel_io_d;
      io_rdata_q    <= io_rdata_d;
      stop_pend_q   <= stop_pend_d;
      sim_stop_q    <= sim_stop_d;
      tx_overflow_q <= tx_overflow_d;
`ifdef MMIO_CYCLE_SNAPSHOT_EN
      snap_q        <= snap_d;
`endif
    end
  end

  mmio_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (fifo_push),
    .push_dat (cpu.cpu_dout),
    .pop      (fifo_pop),
    .pop_dat  (tx_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule
